// File: rtl/note_pattern_engine_if.sv
// Note/motion/pixel bundle for note_pattern_engine.
//   master: drives note_vld, note_idx, up, down, x, y; observes colour,
//           mode, tick and the anchor point.
//   slave : the engine itself.
interface note_pattern_engine_if #(
    parameter int unsigned w_x     = 10,
    parameter int unsigned w_y     = 9,
    parameter int unsigned w_red   = 4,
    parameter int unsigned w_green = 4,
    parameter int unsigned w_blue  = 4
);
    logic               note_vld;
    logic [3:0]         note_idx;
    logic               up;
    logic               down;
    logic [w_x-1:0]     x;
    logic [w_y-1:0]     y;
    logic [w_red-1:0]   red;
    logic [w_green-1:0] green;
    logic [w_blue-1:0]  blue;
    logic [1:0]         mode;
    logic               tick;
    logic [w_x-1:0]     pos_x;
    logic [w_y-1:0]     pos_y;

    modport master (
        output note_vld, note_idx, up, down, x, y,
        input  red, green, blue, mode, tick, pos_x, pos_y
    );

    modport slave (
        input  note_vld, note_idx, up, down, x, y,
        output red, green, blue, mode, tick, pos_x, pos_y
    );
endinterface

// File: rtl/note_pattern_engine.sv
// Note-driven pattern generator.
// Maintains an animated anchor (pos_x, pos_y) stepped by a prescaled tick,
// debounces recognised notes into a sticky note that times out after
// hold_ticks ticks, and renders one of four patterns as registered RGB.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - slave side of note_pattern_engine_if
//          in : note_vld, note_idx, up, down, x, y
//          out: red, green, blue, mode, tick, pos_x, pos_y
module note_pattern_engine #(
    parameter int unsigned screen_width  = 640,
    parameter int unsigned screen_height = 480,
    parameter int unsigned w_red         = 4,
    parameter int unsigned w_green       = 4,
    parameter int unsigned w_blue        = 4,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height),
    parameter int unsigned w_prescale    = 20,
    parameter int unsigned n_notes       = 12,
    parameter int unsigned confirm       = 2,
    parameter int unsigned hold_ticks    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    note_pattern_engine_if.slave  bus
);
    localparam int unsigned w_xy = 2 * ((w_x > w_y) ? w_x : w_y);
    localparam int unsigned w_cc = $clog2(confirm + 1);
    localparam int unsigned w_hc = (hold_ticks > 0) ? $clog2(hold_ticks + 1) : 1;

    localparam logic [3:0]      NOTE_NONE  = 4'hF;
    localparam logic [w_x-1:0]  X_LAST     = w_x'(screen_width - 1);
    localparam logic [w_y-1:0]  Y_LAST     = w_y'(screen_height - 1);
    localparam logic [w_y-1:0]  Y_MID      = w_y'(screen_height / 2);
    localparam logic [w_cc-1:0] CC_MAX     = w_cc'(confirm);
    localparam logic [w_hc-1:0] HOLD_LIMIT = w_hc'(hold_ticks);
    localparam logic [w_xy-1:0] AREA16     = w_xy'(screen_width * screen_height / 16);

    typedef enum logic [1:0] {
        MODE_STRIPE = 2'd0,
        MODE_BOX    = 2'd1,
        MODE_WEDGE  = 2'd2,
        MODE_SPLIT  = 2'd3
    } mode_t;

    function automatic mode_t mode_of(input logic [3:0] idx);
        return mode_t'(2'(idx % 4'd3));
    endfunction

    // ---------------- prescaler and anchor ----------------
    logic [w_prescale-1:0] r_cnt_e;
    logic [w_x-1:0]        r_pos_x;
    logic [w_y-1:0]        r_pos_y;
    logic                  w_tick;

    assign w_tick = &r_cnt_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_e <= '0;
            r_pos_x <= '0;
            r_pos_y <= Y_MID;
        end else begin
            r_cnt_e <= r_cnt_e + w_prescale'(1);
            if (w_tick) begin
                r_pos_x <= (r_pos_x == X_LAST) ? '0 : r_pos_x + w_x'(1);
                if (r_pos_y == '0 || r_pos_y == Y_LAST)
                    r_pos_y <= Y_MID;
                else if (bus.up && !bus.down)
                    r_pos_y <= r_pos_y + w_y'(1);
                else if (bus.down && !bus.up)
                    r_pos_y <= r_pos_y - w_y'(1);
            end
        end
    end

    // ---------------- note debounce / sticky / hold ----------------
    logic [3:0]      r_cand,   w_cand_nx;
    logic [w_cc-1:0] r_cc,     w_cc_nx;
    logic [3:0]      r_sticky, w_sticky_nx;
    mode_t           r_mode,   w_mode_nx;
    logic [w_hc-1:0] r_hold,   w_hold_nx;
    logic [w_hc-1:0] w_hold_inc;
    logic            w_note_ok;

    assign w_hold_inc = r_hold + w_hc'(1);
    assign w_note_ok  = bus.note_vld && ({28'd0, bus.note_idx} < n_notes);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand   <= NOTE_NONE;
            r_cc     <= '0;
            r_sticky <= NOTE_NONE;
            r_mode   <= MODE_SPLIT;
            r_hold   <= '0;
        end else begin
            r_cand   <= w_cand_nx;
            r_cc     <= w_cc_nx;
            r_sticky <= w_sticky_nx;
            r_mode   <= w_mode_nx;
            r_hold   <= w_hold_nx;
        end
    end

    // Timeout is evaluated first so a same-cycle confirmation overrides it.
    // cand_cnt saturates at confirm, so a note that keeps arriving keeps
    // re-confirming and refreshing the hold timer.
    always_comb begin
        w_cand_nx   = r_cand;
        w_cc_nx     = r_cc;
        w_sticky_nx = r_sticky;
        w_mode_nx   = r_mode;
        w_hold_nx   = r_hold;

        if (hold_ticks != 0 && w_tick && r_sticky != NOTE_NONE) begin
            if (w_hold_inc == HOLD_LIMIT) begin
                w_sticky_nx = NOTE_NONE;
                w_mode_nx   = MODE_SPLIT;
                w_hold_nx   = '0;
            end else begin
                w_hold_nx = w_hold_inc;
            end
        end

        if (w_note_ok) begin
            if (bus.note_idx == r_cand) begin
                if (r_cc != CC_MAX)
                    w_cc_nx = r_cc + w_cc'(1);
            end else begin
                w_cand_nx = bus.note_idx;
                w_cc_nx   = w_cc'(1);
            end
            if (w_cc_nx == CC_MAX) begin
                w_sticky_nx = w_cand_nx;
                w_mode_nx   = mode_of(w_cand_nx);
                w_hold_nx   = '0;
            end
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [w_xy-1:0]    w_x_e, w_y_e, w_px_e, w_py_e;
    logic [w_xy-1:0]    w_sum, w_dif, w_dx, w_dy, w_prod, w_psum;
    logic [w_red-1:0]   r_red,   w_red_nx;
    logic [w_green-1:0] r_green, w_green_nx;
    logic [w_blue-1:0]  r_blue,  w_blue_nx;

    assign w_x_e  = w_xy'(bus.x);
    assign w_y_e  = w_xy'(bus.y);
    assign w_px_e = w_xy'(r_pos_x);
    assign w_py_e = w_xy'(r_pos_y);
    assign w_sum  = w_x_e + w_y_e;
    assign w_dif  = w_x_e - w_y_e;
    assign w_dx   = w_x_e - w_px_e;
    assign w_dy   = w_y_e - w_py_e;
    assign w_prod = w_dx * w_dy;
    assign w_psum = w_px_e + w_py_e;

    always_comb begin
        w_red_nx   = '0;
        w_green_nx = '0;
        w_blue_nx  = '0;
        case (r_mode)
            MODE_STRIPE: begin
                if (bus.x < r_pos_x) begin
                    w_red_nx   = w_red'(w_sum >> 3);
                    w_green_nx = w_green'(w_dif >> 3);
                    w_blue_nx  = w_blue'(w_x_e >> 3);
                end
            end
            MODE_BOX: begin
                if (w_prod < AREA16) begin
                    w_red_nx   = w_red'(w_x_e >> 3);
                    w_green_nx = w_green'(w_y_e >> 3);
                    w_blue_nx  = '1;
                end
            end
            MODE_WEDGE: begin
                if (w_sum < w_psum) begin
                    w_red_nx   = '1;
                    w_green_nx = '1;
                    w_blue_nx  = w_blue'(w_sum >> 3);
                end
            end
            MODE_SPLIT: begin
                if (bus.x < r_pos_x)
                    w_red_nx = '1;
                else
                    w_blue_nx = '1;
                if (bus.y < r_pos_y)
                    w_green_nx = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= w_red_nx;
            r_green <= w_green_nx;
            r_blue  <= w_blue_nx;
        end
    end

    assign bus.red   = r_red;
    assign bus.green = r_green;
    assign bus.blue  = r_blue;
    assign bus.mode  = r_mode;
    assign bus.tick  = w_tick;
    assign bus.pos_x = r_pos_x;
    assign bus.pos_y = r_pos_y;
endmodule
